// File: rtl/sort_pkg.sv
// Shared types and width helpers for the bubble-sort index sequencer.
package sort_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned AW_DEF      = 4;
    localparam int unsigned MAX_LEN_DEF = 16;

    // Lengths need one bit more than indices so that 2**AW itself fits.
    function automatic int unsigned len_width(input int unsigned aw);
        return aw + 1;
    endfunction

endpackage

// File: rtl/bounded_counter.sv
// Loadable up-counter with a comparison flag against a runtime limit.
module bounded_counter #(
    parameter int unsigned N = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ld,
    input  logic         en,
    input  logic [N-1:0] d,
    input  logic [N-1:0] limit,
    output logic [N-1:0] q,
    output logic         at_limit
);

    always_ff @(posedge clk) begin
        if (rst)
            q <= '0;
        else if (ld)
            q <= d;
        else if (en)
            q <= q + N'(1);
    end

    assign at_limit = (q == limit);

endmodule

// File: rtl/sort_index_sequencer.sv
// Streams bubble-sort (pass, position) indices over valid/ready, with
// optional early termination after a pass that performed no swap.
module sort_index_sequencer
    import sort_pkg::*;
#(
    parameter int unsigned AW      = AW_DEF,
    parameter int unsigned MAX_LEN = MAX_LEN_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW:0]   len,
    input  logic          early_exit_en,
    input  logic          swapped,
    output logic          idx_valid,
    input  logic          idx_ready,
    output logic [AW-1:0] i_idx,
    output logic [AW-1:0] j_idx,
    output logic          pass_end,
    output logic          busy,
    output logic          done
);

    localparam int unsigned LW = len_width(AW);

    state_t          state, state_nxt;
    logic [LW-1:0]   len_q, len_clamp_c;
    logic [LW-1:0]   i_q, j_q, i_lim_c, j_lim_c;
    logic            i_at_lim, j_at_lim;
    logic            exit_en_q, swap_seen_q;
    logic            i_ld, i_en, j_ld, j_en;
    logic            unused_j_msb;

    assign len_clamp_c = (len > LW'(MAX_LEN)) ? LW'(MAX_LEN) : len;

    // Limits are taken in LW bits so L-2-i cannot wrap for legal i.
    assign i_lim_c = len_q - LW'(2);
    assign j_lim_c = len_q - LW'(2) - i_q;

    bounded_counter #(.N(LW)) u_i_cnt (
        .clk      (clk),
        .rst      (rst),
        .ld       (i_ld),
        .en       (i_en),
        .d        (LW'(0)),
        .limit    (i_lim_c),
        .q        (i_q),
        .at_limit (i_at_lim)
    );

    bounded_counter #(.N(LW)) u_j_cnt (
        .clk      (clk),
        .rst      (rst),
        .ld       (j_ld),
        .en       (j_en),
        .d        (LW'(0)),
        .limit    (j_lim_c),
        .q        (j_q),
        .at_limit (j_at_lim)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        i_ld      = 1'b0;
        i_en      = 1'b0;
        j_ld      = 1'b0;
        j_en      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    i_ld      = 1'b1;
                    j_ld      = 1'b1;
                    state_nxt = (len_clamp_c < LW'(2)) ? DONE : RUN;
                end
            end
            RUN: begin
                if (idx_ready) begin
                    if (!j_at_lim)
                        j_en = 1'b1;
                    else if (i_at_lim || (exit_en_q && !(swap_seen_q || swapped)))
                        state_nxt = DONE;
                    else begin
                        i_en = 1'b1;
                        j_ld = 1'b1;
                    end
                end
            end
            DONE: begin
                i_ld      = 1'b1;
                j_ld      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Run parameters are frozen at the accepted start.
    always_ff @(posedge clk) begin
        if (rst) begin
            len_q     <= '0;
            exit_en_q <= 1'b0;
        end else if (state == IDLE && start) begin
            len_q     <= len_clamp_c;
            exit_en_q <= early_exit_en;
        end
    end

    // Cleared at every pass start (run start or pass advance).
    always_ff @(posedge clk) begin
        if (rst)
            swap_seen_q <= 1'b0;
        else if (i_ld || i_en)
            swap_seen_q <= 1'b0;
        else if (state == RUN && swapped)
            swap_seen_q <= 1'b1;
    end

    assign idx_valid    = (state == RUN);
    assign busy         = (state == RUN);
    assign done         = (state == DONE);
    assign pass_end     = (state == RUN) && j_at_lim;
    assign i_idx        = i_q[AW-1:0];
    assign j_idx        = j_q[AW-1:0];
    assign unused_j_msb = j_q[LW-1];

endmodule

// File: tb/tb_sort_index_sequencer.sv
// Directed self-checking bench for sort_index_sequencer.
module tb_sort_index_sequencer;

    localparam int unsigned AW      = 4;
    localparam int unsigned MAX_LEN = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW:0]   len;
    logic          early_exit_en;
    logic          swapped;
    logic          idx_valid;
    logic          idx_ready;
    logic [AW-1:0] i_idx;
    logic [AW-1:0] j_idx;
    logic          pass_end;
    logic          busy;
    logic          done;

    int total  = 0;
    int passed = 0;
    int nbeats;
    int last_i, last_j;

    sort_index_sequencer #(.AW(AW), .MAX_LEN(MAX_LEN)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .len           (len),
        .early_exit_en (early_exit_en),
        .swapped       (swapped),
        .idx_valid     (idx_valid),
        .idx_ready     (idx_ready),
        .i_idx         (i_idx),
        .j_idx         (j_idx),
        .pass_end      (pass_end),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Starts a run, drives ready/swapped, and checks every presented index
    // (including stalled cycles) against a reference bubble-sort walk.
    task automatic run(input int len_v, input bit early, input logic [15:0] swap_mask,
                       input bit toggle, input bit poke_start,
                       output int beats, output int li, output int lj);
        int L;
        int k;
        int exp_i[$];
        int exp_j[$];
        int exp_pe[$];
        L = (len_v > int'(MAX_LEN)) ? int'(MAX_LEN) : len_v;
        for (int i = 0; i <= L - 2; i++) begin
            for (int j = 0; j <= L - 2 - i; j++) begin
                exp_i.push_back(i);
                exp_j.push_back(j);
                exp_pe.push_back((j == L - 2 - i) ? 1 : 0);
            end
            if (early && !swap_mask[i]) break;
        end
        beats = 0;
        li = -1;
        lj = -1;
        @(negedge clk);
        start = 1'b1;
        len = (AW+1)'(len_v);
        early_exit_en = early;
        @(negedge clk);
        start = 1'b0;
        early_exit_en = 1'b0;
        if (L < 2) begin
            chk("degenerate_done", 32'(done), 1);
            chk("degenerate_valid", 32'(idx_valid), 0);
            chk("degenerate_busy", 32'(busy), 0);
            @(negedge clk);
            chk("degenerate_done_drop", 32'(done), 0);
            return;
        end
        k = 0;
        while (exp_i.size() > 0) begin
            chk("valid", 32'(idx_valid), 1);
            chk("busy", 32'(busy), 1);
            chk("i_idx", 32'(i_idx), 32'(exp_i[0]));
            chk("j_idx", 32'(j_idx), 32'(exp_j[0]));
            chk("pass_end", 32'(pass_end), 32'(exp_pe[0]));
            idx_ready = toggle ? ((k % 4 == 0) || (k % 4 == 3)) : 1'b1;
            swapped = idx_ready && (exp_j[0] == 0) && swap_mask[exp_i[0]];
            start = poke_start && (k == 2);
            len = (AW+1)'(2);
            if (idx_ready) begin
                beats++;
                li = int'(i_idx);
                lj = int'(j_idx);
                void'(exp_i.pop_front());
                void'(exp_j.pop_front());
                void'(exp_pe.pop_front());
            end
            @(negedge clk);
            k++;
        end
        swapped = 1'b0;
        start = 1'b0;
        idx_ready = 1'b1;
        chk("end_done", 32'(done), 1);
        chk("end_valid", 32'(idx_valid), 0);
        chk("end_busy", 32'(busy), 0);
        @(negedge clk);
        chk("idle_done", 32'(done), 0);
        chk("idle_valid", 32'(idx_valid), 0);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        len = '0;
        early_exit_en = 1'b0;
        swapped = 1'b0;
        idx_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(idx_valid), 0);
        chk("rst_pass_end", 32'(pass_end), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_i", 32'(i_idx), 0);
        chk("rst_j", 32'(j_idx), 0);
        rst = 1'b0;

        run(4, 1'b0, 16'h0000, 1'b0, 1'b0, nbeats, last_i, last_j);
        chk("len4_beats", 32'(nbeats), 6);
        chk("len4_last_i", 32'(last_i), 2);
        chk("len4_last_j", 32'(last_j), 0);

        run(4, 1'b0, 16'h0000, 1'b1, 1'b0, nbeats, last_i, last_j);
        chk("len4_stall_beats", 32'(nbeats), 6);

        run(5, 1'b1, 16'h0000, 1'b0, 1'b0, nbeats, last_i, last_j);
        chk("early_noswap_beats", 32'(nbeats), 4);
        chk("early_noswap_last_i", 32'(last_i), 0);
        chk("early_noswap_last_j", 32'(last_j), 3);

        run(5, 1'b1, 16'h0003, 1'b0, 1'b0, nbeats, last_i, last_j);
        chk("early_swap01_beats", 32'(nbeats), 9);
        chk("early_swap01_last_i", 32'(last_i), 2);

        run(0, 1'b0, 16'h0000, 1'b0, 1'b0, nbeats, last_i, last_j);
        run(1, 1'b0, 16'h0000, 1'b0, 1'b0, nbeats, last_i, last_j);

        run(20, 1'b0, 16'h0000, 1'b0, 1'b0, nbeats, last_i, last_j);
        chk("clamp_beats", 32'(nbeats), 120);
        chk("clamp_last_i", 32'(last_i), 14);
        chk("clamp_last_j", 32'(last_j), 0);

        // Abandon a run mid-pass at (1,1).
        @(negedge clk);
        start = 1'b1;
        len = (AW+1)'(4);
        idx_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre_rst_i", 32'(i_idx), 1);
        chk("pre_rst_j", 32'(j_idx), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_valid", 32'(idx_valid), 0);
        chk("midrst_pass_end", 32'(pass_end), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_done", 32'(done), 0);
        chk("midrst_i", 32'(i_idx), 0);
        chk("midrst_j", 32'(j_idx), 0);

        run(3, 1'b0, 16'h0000, 1'b0, 1'b0, nbeats, last_i, last_j);
        chk("len3_beats", 32'(nbeats), 3);
        chk("len3_last_i", 32'(last_i), 1);

        run(4, 1'b0, 16'h0000, 1'b0, 1'b1, nbeats, last_i, last_j);
        chk("poke_start_beats", 32'(nbeats), 6);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
